// File: rtl/controle_multiciclo.sv
// Moore control unit for the 64-bit multicycle RISC-V datapath: one state per cycle,
// memory dwell of MEM_LAT cycles, invalid-opcode/overflow traps through EPC, cause and a fixed vector.
module controle_multiciclo #(
    parameter int          MEM_LAT      = 2,
    parameter logic [63:0] VEC_OPCODE   = 64'd254,
    parameter logic [63:0] VEC_OVERFLOW = 64'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        igual,
    input  logic        overflow,
    output logic [4:0]  estado,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [63:0] vetor,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  mux_reg_sel,
    output logic        ab_load,
    output logic [1:0]  mux_a_sel,
    output logic [1:0]  mux_b_sel,
    output logic [1:0]  alu_op,
    output logic        alu_out_load,
    output logic        mem_write,
    output logic        mdr_load,
    output logic        epc_write,
    output logic        causa_write,
    output logic [10:0] causa
);

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_IR_LOAD  = 5'd2,
        S_DECODE   = 5'd3,
        S_EXEC_R   = 5'd4,
        S_EXEC_I   = 5'd5,
        S_WB_ALU   = 5'd6,
        S_ADDR     = 5'd7,
        S_MEM_RD   = 5'd8,
        S_WB_MEM   = 5'd9,
        S_MEM_WR   = 5'd10,
        S_BRANCH   = 5'd11,
        S_LUI      = 5'd12,
        S_EXC      = 5'd13,
        S_EXC_JUMP = 5'd14,
        S_HALT     = 5'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_HALT   = 7'b1110011;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t      estado_q, estado_d;
    logic [2:0]  cnt_q, cnt_d;
    // pending cause: 0 = invalid opcode, 1 = overflow; also picks the vector
    logic        causa_q, causa_d;
    logic        taken;
    logic        unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign taken  = ((funct3 == 3'b000) && igual) || ((funct3 == 3'b001) && !igual);
    assign estado = estado_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= S_RESET;
            cnt_q    <= 3'd0;
            causa_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            causa_q  <= causa_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = 3'd0;
        causa_d  = causa_q;
        case (estado_q)
            S_RESET:   estado_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == LAT_LAST) begin
                    estado_d = S_IR_LOAD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_IR_LOAD: estado_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         estado_d = S_EXEC_R;
                    OP_I:         estado_d = S_EXEC_I;
                    OP_LD, OP_SD: estado_d = S_ADDR;
                    OP_LUI:       estado_d = S_LUI;
                    OP_HALT:      estado_d = S_HALT;
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b00) begin
                            estado_d = S_BRANCH;
                        end else begin
                            estado_d = S_EXC;
                            causa_d  = 1'b0;
                        end
                    end
                    default: begin
                        estado_d = S_EXC;
                        causa_d  = 1'b0;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                if (overflow) begin
                    estado_d = S_EXC;
                    causa_d  = 1'b1;
                end else begin
                    estado_d = S_WB_ALU;
                end
            end
            // opcode bit 5 separates sd (0100011) from ld (0000011)
            S_ADDR:    estado_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (cnt_q == LAT_LAST) begin
                    estado_d = S_WB_MEM;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_LUI, S_EXC_JUMP:
                       estado_d = S_FETCH;
            S_EXC:     estado_d = S_EXC_JUMP;
            S_HALT:    estado_d = S_HALT;
            default:   estado_d = S_RESET;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        vetor        = 64'd0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mux_reg_sel  = 2'd0;
        ab_load      = 1'b0;
        mux_a_sel    = 2'd0;
        mux_b_sel    = 2'd0;
        alu_op       = 2'd0;
        alu_out_load = 1'b0;
        mem_write    = 1'b0;
        mdr_load     = 1'b0;
        epc_write    = 1'b0;
        causa_write  = 1'b0;
        causa        = 11'd0;
        case (estado_q)
            S_IR_LOAD: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                mux_b_sel = 2'd1;
            end
            S_DECODE: begin
                // speculative branch target: pc_ant + (imm << 1)
                ab_load      = 1'b1;
                alu_out_load = 1'b1;
                mux_a_sel    = 2'd3;
                mux_b_sel    = 2'd3;
            end
            S_EXEC_R: begin
                mux_a_sel    = 2'd1;
                alu_op       = {1'b0, funct7[5]};
                alu_out_load = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                mux_a_sel    = 2'd1;
                mux_b_sel    = 2'd2;
                alu_out_load = 1'b1;
            end
            S_WB_ALU: reg_write = 1'b1;
            S_MEM_RD: mdr_load = (cnt_q == LAT_LAST);
            S_WB_MEM: begin
                reg_write   = 1'b1;
                mux_reg_sel = 2'd1;
            end
            S_MEM_WR: mem_write = 1'b1;
            S_BRANCH: begin
                mux_a_sel = 2'd1;
                alu_op    = 2'd1;
                pc_write  = taken;
                pc_src    = taken ? 2'd1 : 2'd0;
            end
            S_LUI: begin
                reg_write   = 1'b1;
                mux_reg_sel = 2'd2;
            end
            S_EXC: begin
                epc_write   = 1'b1;
                causa_write = 1'b1;
                causa       = {10'd0, causa_q};
            end
            S_EXC_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                vetor    = causa_q ? VEC_OVERFLOW : VEC_OPCODE;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Moore-style control unit that sequences the 64-bit multicycle RISC-V datapath (PC, IR, register bank, ALU, ALU-out, MDR, memory, EPC, cause).
It decodes the IR opcode/funct fields and drives all load/write enables and mux selects, one state per cycle.
It handles invalid-opcode and ALU-overflow exceptions via EPC/cause and a fixed vector.
It exposes its current state on estado for bench monitoring.

Parameters:
MEM_LAT, 2, memory read latency in cycles; dwell length of FETCH and MEM_RD (legal 1..7)
VEC_OPCODE, 254, PC value loaded on invalid-opcode exception
VEC_OVERFLOW, 255, PC value loaded on overflow exception

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
igual  in  1  ALU A==B flag
overflow  in  1  ALU signed overflow flag
estado  out  5  current state code
pc_write  out  1  PC load enable
pc_src  out  2  0=ALU result, 1=ALU-out register, 2=exception vector
vetor  out  64  exception vector value, valid when pc_src=2
ir_write  out  1  IR load (Ld_ir)
reg_write  out  1  register bank write
mux_reg_sel  out  2  write data: 0=ALU-out, 1=MDR, 2=immediate
ab_load  out  1  A/B register load
mux_a_sel  out  2  0=PC, 1=A, 3=PC of current instruction (pc_ant)
mux_b_sel  out  2  0=B, 1=const 4, 2=imm, 3=imm<<1
alu_op  out  2  0=add, 1=sub
alu_out_load  out  1  ALU-out register load
mem_write  out  1  memory write (read otherwise)
mdr_load  out  1  MDR load
epc_write  out  1  EPC <= pc_ant
causa_write  out  1  cause register load
causa  out  11  cause value: 0=invalid opcode, 1=overflow

Behaviour:
- Reset: estado=RESET(0), wait counter=0, all enables/selects/causa/vetor=0. The next edge after deassert enters FETCH.
- Outputs are combinational from estado. BRANCH pc_write also depends on igual/funct3.
- Unlisted outputs in any state are 0.
- FETCH(1): memory address=PC, mem_write=0. Dwell MEM_LAT cycles using a 3-bit counter cleared on entry, then go to IR_LOAD.
- IR_LOAD(2): ir_write=1, pc_write=1, mux_a=0, mux_b=1, add, pc_src=0 (PC+4). Go to DECODE.
- DECODE(3): ab_load=1, alu_out_load=1, mux_a=3, mux_b=3, add (branch target). Dispatch on opcode:
  - 0110011 -> EXEC_R(4)
  - 0010011 -> EXEC_I(5)
  - 0000011 or 0100011 -> ADDR(7)
  - 1100011 with funct3 000/001 -> BRANCH(11)
  - 0110111 -> LUI(12)
  - 1110011 -> HALT(15)
  - anything else -> EXC(13) with pending cause 0
- EXEC_R(4): mux_a=1, mux_b=0, alu_op=funct7[5]?sub:add, alu_out_load=1.
- EXEC_I(5): mux_a=1, mux_b=2, add, alu_out_load=1.
- After EXEC_R/EXEC_I: if overflow=1 in that cycle -> EXC with cause 1 (no register write); else -> WB_ALU(6).
- WB_ALU(6): reg_write=1, mux_reg_sel=0 -> FETCH.
- ADDR(7): mux_a=1, mux_b=2, add, alu_out_load=1. ld -> MEM_RD(8); sd -> MEM_WR(10).
- MEM_RD(8): address=ALU-out. Dwell MEM_LAT cycles; mdr_load=1 on the last cycle only -> WB_MEM(9).
- WB_MEM(9): reg_write=1, mux_reg_sel=1 -> FETCH.
- MEM_WR(10): mem_write=1 for exactly one cycle -> FETCH.
- BRANCH(11): mux_a=1, mux_b=0, sub. Taken = (funct3=000 & igual) | (funct3=001 & !igual). If taken: pc_write=1, pc_src=1. Then -> FETCH.
- LUI(12): reg_write=1, mux_reg_sel=2 -> FETCH.
- EXC(13): epc_write=1, causa_write=1, causa=pending cause (registered at entry) -> EXC_JUMP(14).
- EXC_JUMP(14): pc_write=1, pc_src=2, vetor=VEC_OPCODE or VEC_OVERFLOW -> FETCH.
- HALT(15): all enables 0; remain until reset.
- reg_write and mem_write are never asserted in the same cycle.
- Reset mid-instruction: immediate return to RESET, counter cleared, no further enables asserted.

Test Plan:
- Reset held 3 cycles then released -> estado 0 during reset; FETCH, FETCH, IR_LOAD on the next three edges; ir_write=1 only in IR_LOAD.
- add (opcode 0110011, funct7 0) with no overflow -> 6 cycles per instruction (1,1,2,3,4,6). reg_write pulses once with mux_reg_sel=0; alu_op=1 when funct7=0100000.
- ld with MEM_LAT=2 -> 8 cycles; mdr_load exactly one cycle before WB_MEM. sd -> 6 cycles with a single mem_write pulse.
- beq with igual=1 -> pc_write, pc_src=1 in BRANCH. bne with igual=1 -> no pc_write in BRANCH. Both take 5 cycles.
- opcode 1111111 -> DECODE, EXC (epc_write, causa_write, causa=0), EXC_JUMP (pc_src=2, vetor=254), then FETCH.
- addi with overflow=1 in EXEC_I -> no reg_write; causa=1, vetor=255. opcode 1110011 -> estado stays 15 for 20 cycles. Reset asserted in MEM_RD -> estado=0 asynchronously.
